// File: rtl/amiga_clk_ce_gen_pkg.sv
// Shared types and helpers for the Amiga 28 MHz clock-enable / reset sequencer.
package amiga_clk_ce_gen_pkg;

  localparam int unsigned MAX_VEC_W = 256;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  // Pull field idx (width w) out of a packed per-channel parameter vector.
  function automatic int unsigned field_get(input logic [MAX_VEC_W-1:0] vec,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [MAX_VEC_W-1:0] sh;
    sh = vec >> (idx * w);
    return 32'(sh & ~({MAX_VEC_W{1'b1}} << w));
  endfunction

endpackage

// File: rtl/amiga_clk_ce_gen_div_ch.sv
// One clock-enable channel: wrap counter, phase compare and registered strobe.
module amiga_clk_ce_gen_div_ch
  import amiga_clk_ce_gen_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned PHASE = 0,
  parameter int unsigned CNT_W = 6
) (
  input  logic inclk0,
  input  logic areset,
  input  logic run,
  input  logic clr,
  input  logic en,
  output logic ce
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce_d;

  always_comb begin
    cnt_d = cnt_q;
    ce_d  = run && en && (cnt_q == CNT_W'(PHASE));
    if (!run || clr || (cnt_q == CNT_W'(DIV - 1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce    <= ce_d;
    end
  end

endmodule

// File: rtl/amiga_clk_ce_gen.sv
// Clock-enable generator and reset sequencer for the 28 MHz domain: waits for a
// debounced PLL lock, releases the system reset, then issues phase-aligned strobes.
module amiga_clk_ce_gen
  import amiga_clk_ce_gen_pkg::*;
#(
  parameter int unsigned               NUM_CH      = 4,
  parameter int unsigned               CNT_W       = 6,
  parameter logic [NUM_CH*CNT_W-1:0]   DIVS        = {6'd32, 6'd8, 6'd4, 6'd4},
  parameter logic [NUM_CH*CNT_W-1:0]   PHASES      = {6'd0, 6'd0, 6'd2, 6'd0},
  parameter int unsigned               LOCK_CYCLES = 1024,
  parameter int unsigned               RST_DELAY   = 64
) (
  input  logic              inclk0,
  input  logic              areset,
  input  logic              pll_locked,
  input  logic              resync,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ce_out,
  output logic              rst_out,
  output logic              ready
);

  localparam int unsigned LC_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned RC_W = $clog2(RST_DELAY + 1);

  logic [1:0]      sync_q;
  clk_state_e      state_q;
  logic [LC_W-1:0] lock_cnt_q;
  logic [RC_W-1:0] rst_cnt_q;
  logic            lock_s_c;
  logic            run_c;

  assign lock_s_c = sync_q[1];
  // Lock loss overrides everything, so channels only see RUN while lock holds.
  assign run_c    = (state_q == RUN) && lock_s_c;

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      rst_cnt_q  <= '0;
      rst_out    <= 1'b1;
      ready      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      unique case (state_q)
        WAIT_LOCK: begin
          if (lock_s_c) begin
            state_q    <= STABLE;
            lock_cnt_q <= '0;
          end
        end
        STABLE: begin
          if (!lock_s_c) begin
            state_q <= WAIT_LOCK;
          end else if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
            state_q   <= RUN;
            rst_cnt_q <= '0;
            rst_out   <= (RST_DELAY > 1);
            ready     <= (RST_DELAY == 1);
          end else begin
            lock_cnt_q <= lock_cnt_q + LC_W'(1);
          end
        end
        RUN: begin
          if (!lock_s_c) begin
            state_q <= WAIT_LOCK;
            rst_out <= 1'b1;
            ready   <= 1'b0;
          end else if (rst_out) begin
            // Release lands on the same edge that takes rst_cnt to RST_DELAY-1.
            rst_cnt_q <= rst_cnt_q + RC_W'(1);
            if (rst_cnt_q == RC_W'(RST_DELAY - 2)) begin
              rst_out <= 1'b0;
              ready   <= 1'b1;
            end
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    amiga_clk_ce_gen_div_ch #(
      .DIV   (field_get(MAX_VEC_W'(DIVS), i, CNT_W)),
      .PHASE (field_get(MAX_VEC_W'(PHASES), i, CNT_W)),
      .CNT_W (CNT_W)
    ) u_ch (
      .inclk0 (inclk0),
      .areset (areset),
      .run    (run_c),
      .clr    (resync),
      .en     (ch_mask[i]),
      .ce     (ce_out[i])
    );
  end

endmodule

// File: tb/tb_amiga_clk_ce_gen.sv
// Directed + randomized bench for amiga_clk_ce_gen against a cycle-count reference model.
`timescale 1ns/10ps
module tb_amiga_clk_ce_gen;

  localparam int NUM_CH    = 4;
  localparam int LOCK_CYC  = 1024;
  localparam int RST_DLY   = 64;
  localparam int LC1       = LOCK_CYC + 1;
  localparam int T_RELEASE = 2 + LOCK_CYC + RST_DLY;

  logic              inclk0;
  logic              areset;
  logic              pll_locked;
  logic              resync;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] ce_out;
  logic              rst_out;
  logic              ready;

  int div_m [NUM_CH] = '{4, 4, 8, 32};
  int ph_m  [NUM_CH] = '{0, 2, 0, 0};

  int checks   = 0;
  int failures = 0;

  // Reference model: streak = consecutive edges with synchronised lock high;
  // RUN holds once streak >= LOCK_CYC+1; org = RUN-cycle index where counters were zero.
  bit              lk_q [$];
  int              streak;
  int              org;
  logic [NUM_CH-1:0] exp_ce;
  logic            exp_rst;
  logic            exp_rdy;

  amiga_clk_ce_gen dut (
    .inclk0     (inclk0),
    .areset     (areset),
    .pll_locked (pll_locked),
    .resync     (resync),
    .ch_mask    (ch_mask),
    .ce_out     (ce_out),
    .rst_out    (rst_out),
    .ready      (ready)
  );

  initial inclk0 = 1'b0;
  always #17.45 inclk0 = ~inclk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    lk_q    = '{1'b0, 1'b0};
    streak  = 0;
    org     = 0;
    exp_ce  = '0;
    exp_rst = 1'b1;
    exp_rdy = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    bit run_edge;
    int r;
    ls = lk_q.pop_front();
    lk_q.push_back(pll_locked);
    run_edge = ls && (streak >= LC1);
    r = streak - LC1;
    for (int i = 0; i < NUM_CH; i++)
      exp_ce[i] = run_edge && ch_mask[i] && (((r - org) % div_m[i]) == ph_m[i]);
    if (run_edge && resync) org = r + 1;
    streak = ls ? streak + 1 : 0;
    if (streak == LC1) org = 0;
    exp_rst = !((streak >= LC1) && (streak - LC1 >= RST_DLY - 1));
    exp_rdy = !exp_rst;
  endtask

  function automatic int cur_pos(input int ch);
    return ((streak - LC1) - org) % div_m[ch];
  endfunction

  task automatic tick();
    @(posedge inclk0);
    model_edge();
    #1;
    chk("ce_out", 32'(ce_out), 32'(exp_ce));
    chk("rst_out", 32'(rst_out), 32'(exp_rst));
    chk("ready", 32'(ready), 32'(exp_rdy));
  endtask

  task automatic wait_release(output int n);
    n = 0;
    for (int k = 0; k < T_RELEASE + 200; k++) begin
      tick();
      n++;
      if (rst_out === 1'b0) break;
    end
  endtask

  task automatic rand_run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      if ((k % 16) == 0) ch_mask = 4'($urandom);
      resync = ($urandom_range(0, 15) == 0);
      tick();
    end
    resync = 1'b0;
  endtask

  initial begin
    int n;
    int cnt [NUM_CH];

    areset     = 1'b1;
    pll_locked = 1'b0;
    resync     = 1'b0;
    ch_mask    = 4'hF;
    model_reset();
    #50;
    chk("reset_ce", 32'(ce_out), 32'h0);
    chk("reset_rst", 32'(rst_out), 32'h1);
    chk("reset_ready", 32'(ready), 32'h0);
    @(posedge inclk0);
    #1 areset = 1'b0;
    repeat (5) tick();

    // Lock-up timing from a clean pll_locked rise
    pll_locked = 1'b1;
    wait_release(n);
    chk("release_cycles", 32'(n), 32'(T_RELEASE));
    chk("ready_at_release", 32'(ready), 32'h1);

    // Strobe counts with all channels enabled
    ch_mask = 4'hF;
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    repeat (128) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) if (ce_out[i]) cnt[i]++;
    end
    chk("count_ch0", 32'(cnt[0]), 32'd32);
    chk("count_ch1", 32'(cnt[1]), 32'd32);
    chk("count_ch2", 32'(cnt[2]), 32'd16);
    chk("count_ch3", 32'(cnt[3]), 32'd4);

    rand_run(400);

    // resync while ch2 counter sits at 5
    ch_mask = 4'hF;
    for (int k = 0; k < 20; k++) begin
      if (cur_pos(2) == 5) break;
      tick();
    end
    chk("resync_setup_pos", 32'(cur_pos(2)), 32'd5);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (ce_out[2]) break;
    end
    chk("resync_first_ce2", 32'(n), 32'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (ce_out[2]) break;
    end
    chk("resync_gap_ce2", 32'(n), 32'd8);
    chk("resync_rst_out", 32'(rst_out), 32'h0);

    // Mask channel 0 mid-RUN, then restore
    ch_mask = 4'b1110;
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    repeat (40) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) if (ce_out[i]) cnt[i]++;
    end
    chk("masked_ch0", 32'(cnt[0]), 32'd0);
    chk("masked_ch1", 32'(cnt[1]), 32'd10);
    ch_mask = 4'hF;
    repeat (32) tick();

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick();
    chk("drop_t1_rst", 32'(rst_out), 32'h0);
    tick();
    chk("drop_t2_rst", 32'(rst_out), 32'h0);
    tick();
    chk("drop_t3_ce", 32'(ce_out), 32'h0);
    chk("drop_t3_rst", 32'(rst_out), 32'h1);
    chk("drop_t3_ready", 32'(ready), 32'h0);
    repeat (4) tick();

    // Re-lock with a one-cycle glitch at lock_cnt=500
    pll_locked = 1'b1;
    repeat (503) tick();
    chk("glitch_pre_rst", 32'(rst_out), 32'h1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_release(n);
    chk("glitch_recount", 32'(n), 32'(T_RELEASE));

    rand_run(300);

    // Asynchronous reset mid-RUN
    ch_mask = 4'hF;
    repeat (3) tick();
    areset = 1'b1;
    #3;
    chk("areset_ce", 32'(ce_out), 32'h0);
    chk("areset_rst", 32'(rst_out), 32'h1);
    chk("areset_ready", 32'(ready), 32'h0);
    model_reset();
    repeat (2) @(posedge inclk0);
    #1 areset = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
